alu_rs: RTL
===========

// Module: alu_rs
// PURPOSE
//  Reservation station and issue scheduler for the single-cycle ALU. Buffers decoded
//  ALU/branch/jump uops from dispatch and captures operands from two CDBs (ALU, LSB).
//  Each cycle it issues the lowest-index ready entry to the ALU issue port
//  (yes/op/v1/v2/pc/is_short/imm/rob_id). Sits between decoder/ROB dispatch and alu.
// PARAMETERS
//  DEPTH  8  number of RS entries (power of 2, 2..16)
//  ROB_W  4  ROB tag width, equal to the `ROB_R range width
// PORTS
//  clk_in        in   1      clock, posedge
//  rst_in        in   1      reset, asynchronous, active-low
//  rdy_in        in   1      global enable; low = stall (state held)
//  flush         in   1      mispredict flush, synchronous
//  disp_valid    in   1      dispatch request
//  disp_op       in   11     {funct7b5, funct3, opcode}, ALU op encoding
//  disp_q1_busy  in   1      rs1 value pending
//  disp_q1       in   ROB_W  rs1 producer ROB tag
//  disp_v1       in   32     rs1 value (valid when !disp_q1_busy)
//  disp_q2_busy  in   1      rs2 value pending (0 for ops without rs2)
//  disp_q2       in   ROB_W  rs2 producer ROB tag
//  disp_v2       in   32     rs2 value
//  disp_pc       in   32     instruction PC
//  disp_is_short in   1      compressed instruction
//  disp_imm      in   32     immediate
//  disp_rob_id   in   ROB_W  destination ROB tag
//  cdb0_valid/cdb0_rob_id/cdb0_value  in 1/ROB_W/32  ALU result bus
//  cdb1_valid/cdb1_rob_id/cdb1_value  in 1/ROB_W/32  LSB result bus
//  rs_full       out  1      combinational: all entries busy
//  alu_yes       out  1      issue valid (registered)
//  alu_op        out  11     issued op
//  alu_v1, alu_v2 out 32     issued operands
//  alu_pc        out  32     issued PC
//  alu_is_short  out  1      issued compressed flag
//  alu_imm       out  32     issued immediate
//  alu_rob_id    out  ROB_W  issued ROB tag
// BEHAVIOUR
//  - Reset (rst_in=0, async): all entries non-busy; every output 0; rs_full=0.
//  - Entry state: busy, op, q1_busy, q1, v1, q2_busy, q2, v2, pc, is_short, imm, rob_id.
//  - Dispatch: when disp_valid && !rs_full && !flush && rdy_in, write the lowest-index
//    free entry (from pre-edge busy vector). Dispatch while full is dropped silently;
//    the dispatcher must gate on rs_full.
//  - Same-cycle capture: a dispatched operand whose tag matches a valid CDB in that
//    cycle stores the CDB value with q_busy=0. If both CDBs match, cdb0 wins.
//  - Wakeup: each busy entry with q_busy and tag == valid CDB tag captures the value
//    and clears q_busy at the edge. Both operands may wake in the same cycle.
//  - Select: ready = busy && !q1_busy && !q2_busy on registered state. The lowest
//    ready index issues. At the edge: alu_* <= entry fields, alu_yes <= 1, entry busy <= 0.
//    With no ready entry, alu_yes <= 0 and other alu_* hold.
//  - Latency: ready-on-dispatch uop written at edge N -> alu_yes high after edge N+1.
//    An entry woken at edge N issues at edge N+1 at the earliest. No same-cycle
//    dispatch-to-issue.
//  - A slot freed by issue is reusable from the next cycle (not the same edge).
//  - Flush (rdy_in=1): at the edge all busy <= 0, alu_yes <= 0, dispatch ignored.
//    Flush overrides issue and wakeup.
//  - rdy_in=0: no dispatch, wakeup, issue or flush; all entries hold; alu_yes <= 0.
//    CDB results arriving while stalled are lost. Upstream holds CDBs during stall.
//  - Reset mid-operation discards all entries immediately.
//  - rs_full = &busy (combinational from registered busy).
// TESTING
//  1 Reset, dispatch addi (q1_busy=0, v1=5, imm=3, rob 2) -> alu_yes=1 two edges later,
//    alu_v1=5, alu_imm=3, alu_rob_id=2, entry freed.
//  2 Dispatch add, q1=rob4 pending, v2=7; next cycle cdb1 {4, 0x10} -> issue next edge
//    with alu_v1=0x10, alu_v2=7.
//  3 Dispatch with q1=rob6 while cdb0 {6, 0xAB} is valid the same cycle -> captured,
//    issues with v1=0xAB; no wait.
//  4 Fill DEPTH entries all pending -> rs_full=1, extra dispatch dropped; wake entries
//    3 and 1 together -> entry 1 issues first, then entry 3.
//  5 Four pending entries, assert flush -> alu_yes=0 next edge, rs_full=0, later CDB
//    matches issue nothing.
//  6 Ready entry with rdy_in=0 for 3 cycles -> alu_yes=0 throughout; issues on first
//    edge after rdy_in=1.

Source files
------------

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue bundle for the ALU reservation station.
// The RS uses the slave view; the dispatcher/bench uses the master view.
interface alu_rs_if #(
    parameter int ROB_W = 4
);
    logic             disp_valid;
    logic [10:0]      disp_op;
    logic             disp_q1_busy;
    logic [ROB_W-1:0] disp_q1;
    logic [31:0]      disp_v1;
    logic             disp_q2_busy;
    logic [ROB_W-1:0] disp_q2;
    logic [31:0]      disp_v2;
    logic [31:0]      disp_pc;
    logic             disp_is_short;
    logic [31:0]      disp_imm;
    logic [ROB_W-1:0] disp_rob_id;

    logic             cdb0_valid;
    logic [ROB_W-1:0] cdb0_rob_id;
    logic [31:0]      cdb0_value;
    logic             cdb1_valid;
    logic [ROB_W-1:0] cdb1_rob_id;
    logic [31:0]      cdb1_value;

    logic             rs_full;
    logic             alu_yes;
    logic [10:0]      alu_op;
    logic [31:0]      alu_v1;
    logic [31:0]      alu_v2;
    logic [31:0]      alu_pc;
    logic             alu_is_short;
    logic [31:0]      alu_imm;
    logic [ROB_W-1:0] alu_rob_id;

    modport slave (
        input  disp_valid, disp_op, disp_q1_busy, disp_q1, disp_v1,
               disp_q2_busy, disp_q2, disp_v2, disp_pc, disp_is_short,
               disp_imm, disp_rob_id,
               cdb0_valid, cdb0_rob_id, cdb0_value,
               cdb1_valid, cdb1_rob_id, cdb1_value,
        output rs_full, alu_yes, alu_op, alu_v1, alu_v2, alu_pc,
               alu_is_short, alu_imm, alu_rob_id
    );

    modport master (
        output disp_valid, disp_op, disp_q1_busy, disp_q1, disp_v1,
               disp_q2_busy, disp_q2, disp_v2, disp_pc, disp_is_short,
               disp_imm, disp_rob_id,
               cdb0_valid, cdb0_rob_id, cdb0_value,
               cdb1_valid, cdb1_rob_id, cdb1_value,
        input  rs_full, alu_yes, alu_op, alu_v1, alu_v2, alu_pc,
               alu_is_short, alu_imm, alu_rob_id
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers uops, snoops two CDBs for operands and
// issues the lowest-index ready entry to the single-cycle ALU each cycle.
module alu_rs #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush,
    alu_rs_if.slave  bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             busy;
        logic [10:0]      op;
        logic             q1_busy;
        logic [ROB_W-1:0] q1;
        logic [31:0]      v1;
        logic             q2_busy;
        logic [ROB_W-1:0] q2;
        logic [31:0]      v2;
        logic [31:0]      pc;
        logic             is_short;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob_id;
    } ent_t;

    typedef struct packed {
        logic             yes;
        logic [10:0]      op;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [31:0]      pc;
        logic             is_short;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob_id;
    } iss_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    iss_t             iss_q;
    iss_t             iss_d;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    sel_idx;
    logic             has_free;
    logic             has_sel;

    // Returns {still_pending, value}; cdb0 has priority over cdb1.
    function automatic logic [32:0] snoop(
        input logic             pend,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      val
    );
        if (pend && bus.cdb0_valid && bus.cdb0_rob_id == tag)
            return {1'b0, bus.cdb0_value};
        if (pend && bus.cdb1_valid && bus.cdb1_rob_id == tag)
            return {1'b0, bus.cdb1_value};
        return {pend, val};
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy[i]  = ent_q[i].busy;
            ready[i] = ent_q[i].busy && !ent_q[i].q1_busy
                       && !ent_q[i].q2_busy;
        end
    end

    assign bus.rs_full = &busy;

    always_comb begin
        free_idx = '0;
        has_free = 1'b0;
        sel_idx  = '0;
        has_sel  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IW'(i);
                has_free = 1'b1;
            end
            if (ready[i]) begin
                sel_idx = IW'(i);
                has_sel = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        iss_d     = iss_q;
        iss_d.yes = 1'b0;
        if (rdy_in && flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].busy) begin
                    {ent_d[i].q1_busy, ent_d[i].v1} =
                        snoop(ent_q[i].q1_busy, ent_q[i].q1, ent_q[i].v1);
                    {ent_d[i].q2_busy, ent_d[i].v2} =
                        snoop(ent_q[i].q2_busy, ent_q[i].q2, ent_q[i].v2);
                end
            end
            if (has_sel) begin
                iss_d.yes      = 1'b1;
                iss_d.op       = ent_q[sel_idx].op;
                iss_d.v1       = ent_q[sel_idx].v1;
                iss_d.v2       = ent_q[sel_idx].v2;
                iss_d.pc       = ent_q[sel_idx].pc;
                iss_d.is_short = ent_q[sel_idx].is_short;
                iss_d.imm      = ent_q[sel_idx].imm;
                iss_d.rob_id   = ent_q[sel_idx].rob_id;
                ent_d[sel_idx].busy = 1'b0;
            end
            // Free slot comes from pre-edge busy, so it never aliases the issuer.
            if (bus.disp_valid && has_free) begin
                ent_d[free_idx].busy     = 1'b1;
                ent_d[free_idx].op       = bus.disp_op;
                ent_d[free_idx].q1       = bus.disp_q1;
                ent_d[free_idx].q2       = bus.disp_q2;
                ent_d[free_idx].pc       = bus.disp_pc;
                ent_d[free_idx].is_short = bus.disp_is_short;
                ent_d[free_idx].imm      = bus.disp_imm;
                ent_d[free_idx].rob_id   = bus.disp_rob_id;
                {ent_d[free_idx].q1_busy, ent_d[free_idx].v1} =
                    snoop(bus.disp_q1_busy, bus.disp_q1, bus.disp_v1);
                {ent_d[free_idx].q2_busy, ent_d[free_idx].v2} =
                    snoop(bus.disp_q2_busy, bus.disp_q2, bus.disp_v2);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            iss_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            iss_q <= iss_d;
        end
    end

    assign bus.alu_yes      = iss_q.yes;
    assign bus.alu_op       = iss_q.op;
    assign bus.alu_v1       = iss_q.v1;
    assign bus.alu_v2       = iss_q.v2;
    assign bus.alu_pc       = iss_q.pc;
    assign bus.alu_is_short = iss_q.is_short;
    assign bus.alu_imm      = iss_q.imm;
    assign bus.alu_rob_id   = iss_q.rob_id;
endmodule
